// File: rtl/peripheral_dbg_pu_or1k_jsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_dbg_pu_or1k_jsp_pkg
// Brief    : Shared types and constants for the JSP Wishbone master.
//            Holds the master FSM state type, register offsets, byte
//            selects, LSR bit positions and the FIFO/line init word.
// Revision : 1.0 - initial release
// ============================================================================
package peripheral_dbg_pu_or1k_jsp_pkg;

    // Master FSM states
    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_GAP    = 3'd1,
        ST_LSR_RD = 3'd2,
        ST_RX_RD  = 3'd3,
        ST_TX_WR  = 3'd4
    } jsp_state_t;

    // Register bank offsets relative to BASE_ADDR (bit 2 selects the bank)
    localparam logic [31:0] c_ofs_rbr_thr = 32'h0000_0000;
    localparam logic [31:0] c_ofs_fcr_lcr = 32'h0000_0000;
    localparam logic [31:0] c_ofs_lsr     = 32'h0000_0004;

    // Byte selects for each register lane
    localparam logic [3:0]  c_sel_data    = 4'b1000;   // RBR/THR [31:24]
    localparam logic [3:0]  c_sel_lsr     = 4'b0100;   // LSR     [23:16]
    localparam logic [3:0]  c_sel_init    = 4'b0011;   // FCR+LCR [15:0]

    // LSR bit positions
    localparam int          c_lsr_dr      = 0;         // RX data ready
    localparam int          c_lsr_thre    = 5;         // THR has space

    // LCR=0x00 clears DLAB, FCR=0x06 resets both slave FIFOs
    localparam logic [31:0] c_init_data   = 32'h0000_0600;

endpackage
`default_nettype wire

// File: rtl/peripheral_dbg_pu_or1k_jsp_wbm_rxreg.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_dbg_pu_or1k_jsp_wbm_rxreg
// Brief    : Single-entry valid/ready holding register for bytes popped
//            from the JSP receive buffer.
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_dbg_pu_or1k_jsp_wbm_rxreg (
    input  logic       wb_clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       valid_o
);

    logic [7:0] r_data;
    logic       r_valid;

    // Load a new byte from the bus; drop valid once the consumer takes it
    always_ff @(posedge wb_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
        end else if (load_i) begin
            r_data  <= load_data_i;
            r_valid <= 1'b1;
        end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;

endmodule
`default_nettype wire

// File: rtl/peripheral_dbg_pu_or1k_jsp_wbm.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_dbg_pu_or1k_jsp_wbm
// Brief    : Wishbone master servicing the JSP 16550-subset slave. Polls
//            LSR, pops RBR bytes onto an RX stream and pushes TX stream
//            bytes into THR, with per-access timeout and sticky bus error.
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_dbg_pu_or1k_jsp_wbm
    import peripheral_dbg_pu_or1k_jsp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          POLL_GAP  = 4,
    parameter int          TIMEOUT   = 64
) (
    input  logic        wb_clk_i,
    input  logic        rst_i,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic        bus_err_o
);

    localparam logic [7:0]  c_gap_reload = 8'(POLL_GAP);
    localparam logic [15:0] c_tmo_last   = 16'(TIMEOUT - 1);

    jsp_state_t  r_state, w_state_nxt;
    logic        r_cyc, w_cyc_nxt;
    logic        r_we, w_we_nxt;
    logic [31:0] r_adr, w_adr_nxt;
    logic [3:0]  r_sel, w_sel_nxt;
    logic [31:0] r_dat, w_dat_nxt;
    logic [7:0]  r_gap, w_gap_nxt;
    logic [15:0] r_tmo, w_tmo_nxt;
    logic        r_rr, w_rr_nxt;
    logic        r_tx_ready, w_tx_ready_nxt;
    logic        r_bus_err, w_bus_err_nxt;
    logic        w_rx_load;

    // Access outcome: ack wins over a coincident timeout, err wins over ack
    logic w_tmo_hit, w_done, w_fail, w_rx_cand, w_tx_cand, w_unused_dat;
    assign w_tmo_hit = (r_tmo == c_tmo_last);
    assign w_done    = r_cyc & wbm_ack_i & ~wbm_err_i;
    assign w_fail    = r_cyc & (wbm_err_i | (w_tmo_hit & ~wbm_ack_i));
    assign w_rx_cand = wbm_dat_i[16 + c_lsr_dr] & ~rx_valid_o;
    assign w_tx_cand = wbm_dat_i[16 + c_lsr_thre] & tx_valid_i;
    assign w_unused_dat = ^wbm_dat_i;

    // Next-state and next-bus-value decode
    always_comb begin
        w_state_nxt    = r_state;
        w_cyc_nxt      = r_cyc;
        w_we_nxt       = r_we;
        w_adr_nxt      = r_adr;
        w_sel_nxt      = r_sel;
        w_dat_nxt      = r_dat;
        w_gap_nxt      = r_gap;
        w_tmo_nxt      = r_cyc ? (r_tmo + 16'd1) : 16'd0;
        w_rr_nxt       = r_rr;
        w_tx_ready_nxt = 1'b0;
        w_bus_err_nxt  = r_bus_err | w_fail;
        w_rx_load      = 1'b0;

        // Any termination drops the strobe on the sampling edge
        if (w_done || w_fail) begin
            w_cyc_nxt = 1'b0;
            w_tmo_nxt = 16'd0;
        end

        unique case (r_state)
            ST_INIT: begin
                // A failed init stays here and is reissued after one idle cycle
                if (!r_cyc) begin
                    w_cyc_nxt = 1'b1;
                    w_we_nxt  = 1'b1;
                    w_adr_nxt = BASE_ADDR + c_ofs_fcr_lcr;
                    w_sel_nxt = c_sel_init;
                    w_dat_nxt = c_init_data;
                end else if (w_done) begin
                    w_state_nxt = ST_GAP;
                end
            end

            ST_GAP: begin
                // The GAP cycle itself is the mandatory idle before the poll
                if (r_gap == 8'd0) begin
                    w_state_nxt = ST_LSR_RD;
                    w_gap_nxt   = c_gap_reload;
                    w_cyc_nxt   = 1'b1;
                    w_we_nxt    = 1'b0;
                    w_adr_nxt   = BASE_ADDR + c_ofs_lsr;
                    w_sel_nxt   = c_sel_lsr;
                    w_dat_nxt   = 32'h0;
                end else begin
                    w_gap_nxt = r_gap - 8'd1;
                end
            end

            ST_LSR_RD: begin
                if (w_done) begin
                    if (w_rx_cand && (!w_tx_cand || !r_rr)) begin
                        w_state_nxt = ST_RX_RD;
                    end else if (w_tx_cand) begin
                        w_state_nxt = ST_TX_WR;
                        w_dat_nxt   = {tx_data_i, 24'h0};
                    end else begin
                        w_state_nxt = ST_GAP;
                    end
                    if (w_rx_cand && w_tx_cand) begin
                        w_rr_nxt = ~r_rr;
                    end
                end else if (w_fail) begin
                    w_state_nxt = ST_GAP;
                end
            end

            ST_RX_RD: begin
                if (!r_cyc) begin
                    w_cyc_nxt = 1'b1;
                    w_we_nxt  = 1'b0;
                    w_adr_nxt = BASE_ADDR + c_ofs_rbr_thr;
                    w_sel_nxt = c_sel_data;
                    w_dat_nxt = 32'h0;
                end else if (w_done) begin
                    w_rx_load   = 1'b1;
                    w_state_nxt = ST_GAP;
                end else if (w_fail) begin
                    w_state_nxt = ST_GAP;
                end
            end

            ST_TX_WR: begin
                // Write data was latched on entry; only the strobe is raised here
                if (!r_cyc) begin
                    w_cyc_nxt = 1'b1;
                    w_we_nxt  = 1'b1;
                    w_adr_nxt = BASE_ADDR + c_ofs_rbr_thr;
                    w_sel_nxt = c_sel_data;
                end else if (w_done) begin
                    w_tx_ready_nxt = 1'b1;
                    w_state_nxt    = ST_GAP;
                end else if (w_fail) begin
                    w_state_nxt = ST_GAP;
                end
            end

            default: begin
                w_state_nxt = ST_INIT;
                w_cyc_nxt   = 1'b0;
            end
        endcase
    end

    // State and bus register bank
    always_ff @(posedge wb_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_INIT;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= 32'h0;
            r_sel      <= 4'h0;
            r_dat      <= 32'h0;
            r_gap      <= c_gap_reload;
            r_tmo      <= 16'd0;
            r_rr       <= 1'b0;
            r_tx_ready <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc      <= w_cyc_nxt;
            r_we       <= w_we_nxt;
            r_adr      <= w_adr_nxt;
            r_sel      <= w_sel_nxt;
            r_dat      <= w_dat_nxt;
            r_gap      <= w_gap_nxt;
            r_tmo      <= w_tmo_nxt;
            r_rr       <= w_rr_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_bus_err  <= w_bus_err_nxt;
        end
    end

    peripheral_dbg_pu_or1k_jsp_wbm_rxreg u_rxreg (
        .wb_clk_i    (wb_clk_i),
        .rst_i       (rst_i),
        .load_i      (w_rx_load),
        .load_data_i (wbm_dat_i[31:24]),
        .ready_i     (rx_ready_i),
        .data_o      (rx_data_o),
        .valid_o     (rx_valid_o)
    );

    assign wbm_cyc_o  = r_cyc;
    assign wbm_stb_o  = r_cyc;
    assign wbm_we_o   = r_we;
    assign wbm_adr_o  = r_adr;
    assign wbm_sel_o  = r_sel;
    assign wbm_dat_o  = r_dat;
    assign wbm_cti_o  = 3'b000;
    assign wbm_bte_o  = 2'b00;
    assign tx_ready_o = r_tx_ready;
    assign bus_err_o  = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_dbg_pu_or1k_jsp_wbm.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_dbg_pu_or1k_jsp_wbm
// Brief    : Self-checking bench: behavioural JSP slave, RX consumer and
//            TX producer with byte queues as the reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_dbg_pu_or1k_jsp_wbm;

    localparam logic [31:0] P_BASE = 32'h0000_2000;
    localparam int          P_GAP  = 2;
    localparam int          P_TMO  = 8;

    logic        wb_clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i, wbm_err_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o, rx_ready_i;
    logic [7:0]  tx_data_i;
    logic        tx_valid_i, tx_ready_o, bus_err_o;

    always #5 wb_clk_i = ~wb_clk_i;

    peripheral_dbg_pu_or1k_jsp_wbm #(
        .BASE_ADDR (P_BASE),
        .POLL_GAP  (P_GAP),
        .TIMEOUT   (P_TMO)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .rst_i      (rst_i),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_cti_o  (wbm_cti_o),
        .wbm_bte_o  (wbm_bte_o),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_err_i  (wbm_err_i),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .bus_err_o  (bus_err_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [7:0] host_q[$];     // bytes still inside the slave RX FIFO
    logic [7:0] exp_rx[$];     // every byte the host ever sent
    logic [7:0] got_rx[$];     // bytes taken by the consumer
    logic [7:0] src_q[$];      // TX bytes not yet accepted
    logic [7:0] src_all[$];    // every TX byte offered
    logic [7:0] thr_log[$];    // bytes written into THR
    int         kind_q[$];     // 1 = RBR read, 2 = THR write
    logic       thre = 1'b1;
    logic       stall_rbr = 1'b0;
    int         rx_mode = 1;   // 0 hold low, 1 high, 2 random
    int         n_smp = 0, last_end = 0, dly = 0, stb_cnt = 0, stall_len = 0, stall_seen = 0;
    int         lsr_rd = 0, rbr_rd = 0, init_wr = 0, gap_err = 0, stab_err = 0, odd_cnt = 0;
    int         tx_pulses = 0;
    bit         in_req = 0, first_done = 0;
    logic [31:0] s_adr, s_dat, f_adr, f_dat;
    logic [3:0]  s_sel, f_sel;
    logic        s_we, f_we;

    // Wishbone slave: random ack latency, optional RBR stall, logs completions
    initial begin
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = 32'h0;
        forever begin
            @(posedge wb_clk_i); #1;
            n_smp++;
            if (wbm_ack_i) begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = 32'h0;
                if (!first_done) begin
                    first_done = 1; f_adr = s_adr; f_dat = s_dat; f_sel = s_sel; f_we = s_we;
                end
                if (s_adr == P_BASE + 32'h4 && !s_we && s_sel == 4'b0100) lsr_rd++;
                else if (s_adr == P_BASE && !s_we && s_sel == 4'b1000) begin
                    rbr_rd++; kind_q.push_back(1);
                    if (host_q.size() > 0) void'(host_q.pop_front());
                end else if (s_adr == P_BASE && s_we && s_sel == 4'b1000 && s_dat[23:0] == 24'h0) begin
                    thr_log.push_back(s_dat[31:24]); kind_q.push_back(2);
                end else if (s_adr == P_BASE && s_we && s_sel == 4'b0011 && s_dat == 32'h0000_0600)
                    init_wr++;
                else odd_cnt++;
                in_req = 0; last_end = n_smp;
            end else if (wbm_cyc_o && wbm_stb_o) begin
                if (!in_req) begin
                    in_req = 1; stb_cnt = 0; dly = $urandom_range(0, 2);
                    s_adr = wbm_adr_o; s_dat = wbm_dat_o; s_sel = wbm_sel_o; s_we = wbm_we_o;
                    if (!(wbm_we_o && wbm_sel_o == 4'b0011)) begin
                        if ((n_smp - last_end) != ((wbm_adr_o == P_BASE + 32'h4) ? P_GAP + 1 : 1))
                            gap_err++;
                    end
                end else if (wbm_adr_o !== s_adr || wbm_dat_o !== s_dat ||
                             wbm_sel_o !== s_sel || wbm_we_o !== s_we) begin
                    stab_err++;
                end
                stb_cnt++;
                if (!(stall_rbr && s_adr == P_BASE && !s_we)) begin
                    if (dly == 0) begin
                        wbm_ack_i = 1'b1;
                        if (s_adr == P_BASE + 32'h4)
                            wbm_dat_i = {8'($urandom), (8'($urandom) & 8'hDE) | {2'b00, thre, 4'b0000,
                                         (host_q.size() > 0)}, 16'($urandom)};
                        else if (!s_we && host_q.size() > 0)
                            wbm_dat_i = {host_q[0], 24'($urandom)};
                        else
                            wbm_dat_i = $urandom;
                    end else begin
                        dly--;
                    end
                end
            end else if (in_req) begin
                stall_len = stb_cnt; stall_seen++;
                in_req = 0; last_end = n_smp;
            end
        end
    end

    // RX consumer: a byte is taken when valid and ready meet at the next edge
    initial begin
        rx_ready_i = 1'b0;
        forever begin
            @(posedge wb_clk_i); #1;
            rx_ready_i = (rx_mode == 1) ? 1'b1 : (rx_mode == 2) ? 1'($urandom) : 1'b0;
            if (rx_valid_o && rx_ready_i) got_rx.push_back(rx_data_o);
        end
    end

    // TX producer: hold the byte until tx_ready_o has been seen for it
    initial begin
        bit adv;
        adv = 0; tx_valid_i = 1'b0; tx_data_i = 8'h00;
        forever begin
            @(posedge wb_clk_i); #1;
            if (adv) begin void'(src_q.pop_front()); adv = 0; end
            if (tx_ready_o) tx_pulses++;
            tx_valid_i = (src_q.size() > 0);
            tx_data_i  = (src_q.size() > 0) ? src_q[0] : 8'h00;
            if (tx_valid_i && tx_ready_o) adv = 1;
        end
    end

    task automatic send_host(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            host_q.push_back(b); exp_rx.push_back(b);
        end
    endtask

    task automatic send_tx(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            src_q.push_back(b); src_all.push_back(b);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge wb_clk_i);
    endtask

    initial begin
        int rb0, lr0, ss0, rep, mis;
        rst_i = 1'b1;
        wait_cyc(3); #2;
        check_eq("rst_cyc", wbm_cyc_o, 0);
        check_eq("rst_stb", wbm_stb_o, 0);
        check_eq("rst_we", wbm_we_o, 0);
        check_eq("rst_adr", wbm_adr_o, 0);
        check_eq("rst_sel", wbm_sel_o, 0);
        check_eq("rst_dat", wbm_dat_o, 0);
        check_eq("rst_cti", wbm_cti_o, 0);
        check_eq("rst_bte", wbm_bte_o, 0);
        check_eq("rst_rx_valid", rx_valid_o, 0);
        check_eq("rst_rx_data", rx_data_o, 0);
        check_eq("rst_tx_ready", tx_ready_o, 0);
        check_eq("rst_bus_err", bus_err_o, 0);
        @(negedge wb_clk_i); rst_i = 1'b0;

        // Init write, then idle polling
        for (int i = 0; i < 50 && !first_done; i++) wait_cyc(1);
        check_eq("init_seen", first_done, 1);
        check_eq("init_we", f_we, 1);
        check_eq("init_adr", f_adr, P_BASE);
        check_eq("init_sel", f_sel, 4'b0011);
        check_eq("init_dat", f_dat, 32'h0000_0600);
        wait_cyc(40);
        check_eq("idle_polls", lsr_rd > 4, 1);
        check_eq("idle_no_data", kind_q.size(), 0);
        check_eq("idle_bus_err", bus_err_o, 0);

        // Two host bytes, consumer always ready
        rb0 = rbr_rd; rx_mode = 1; send_host(2);
        for (int i = 0; i < 200 && got_rx.size() < 2; i++) wait_cyc(1);
        check_eq("rx2_count", got_rx.size(), 2);
        check_eq("rx2_b0", got_rx.size() > 0 ? got_rx[0] : 8'hxx, exp_rx[0]);
        check_eq("rx2_b1", got_rx.size() > 1 ? got_rx[1] : 8'hxx, exp_rx[1]);
        check_eq("rx2_reads", rbr_rd - rb0, 2);

        // Back-pressure: consumer stalled with three bytes pending
        rb0 = rbr_rd; rx_mode = 0; send_host(3);
        wait_cyc(80);
        check_eq("bp_reads", rbr_rd - rb0, 1);
        check_eq("bp_valid", rx_valid_o, 1);
        check_eq("bp_data", rx_data_o, exp_rx[2]);
        rx_mode = 1;
        for (int i = 0; i < 300 && got_rx.size() < 5; i++) wait_cyc(1);
        check_eq("bp_count", got_rx.size(), 5);
        check_eq("bp_reads_all", rbr_rd - rb0, 3);

        // Single TX byte with space, then blocked by THRE=0
        thre = 1'b1; send_tx(1);
        for (int i = 0; i < 200 && thr_log.size() < 1; i++) wait_cyc(1);
        wait_cyc(5);
        check_eq("tx1_count", thr_log.size(), 1);
        check_eq("tx1_byte", thr_log.size() > 0 ? thr_log[0] : 8'hxx, src_all[0]);
        check_eq("tx1_pulses", tx_pulses, 1);
        thre = 1'b0; send_tx(1);
        wait_cyc(60);
        check_eq("txblk_count", thr_log.size(), 1);
        check_eq("txblk_pulses", tx_pulses, 1);
        thre = 1'b1;
        for (int i = 0; i < 200 && thr_log.size() < 2; i++) wait_cyc(1);
        check_eq("txunblk_byte", thr_log.size() > 1 ? thr_log[1] : 8'hxx, src_all[1]);

        // Both directions pending: accesses must alternate
        kind_q.delete(); send_host(6); send_tx(6);
        for (int i = 0; i < 1000 && (got_rx.size() < 11 || thr_log.size() < 8); i++) wait_cyc(1);
        check_eq("alt_len", kind_q.size(), 12);
        rep = 0;
        for (int i = 1; i < kind_q.size(); i++) if (kind_q[i] == kind_q[i-1]) rep++;
        check_eq("alt_repeats", rep, 0);

        // Random traffic on both streams
        rx_mode = 2; send_host(20); send_tx(20);
        for (int i = 0; i < 6000 && (got_rx.size() < exp_rx.size() || src_q.size() > 0); i++) begin
            @(negedge wb_clk_i); thre = 1'($urandom);
        end
        thre = 1'b1; rx_mode = 1;
        wait_cyc(10);
        check_eq("rnd_rx_count", got_rx.size(), exp_rx.size());
        check_eq("rnd_tx_count", thr_log.size(), src_all.size());
        mis = 0;
        for (int i = 0; i < exp_rx.size() && i < got_rx.size(); i++) if (got_rx[i] !== exp_rx[i]) mis++;
        for (int i = 0; i < src_all.size() && i < thr_log.size(); i++) if (thr_log[i] !== src_all[i]) mis++;
        check_eq("rnd_order", mis, 0);
        check_eq("rnd_pulses", tx_pulses, src_all.size());
        check_eq("rnd_reads", rbr_rd, exp_rx.size());
        check_eq("rnd_bus_err", bus_err_o, 0);

        // Slave never acks RBR: timeout, sticky error, polling resumes
        stall_rbr = 1'b1; ss0 = stall_seen; send_host(1);
        for (int i = 0; i < 300 && stall_seen == ss0; i++) wait_cyc(1);
        check_eq("tmo_seen", stall_seen > ss0, 1);
        check_eq("tmo_len", stall_len, P_TMO);
        check_eq("tmo_bus_err", bus_err_o, 1);
        check_eq("tmo_rx_valid", rx_valid_o, 0);
        lr0 = lsr_rd;
        for (int i = 0; i < 100 && lsr_rd == lr0; i++) wait_cyc(1);
        check_eq("tmo_poll_resume", lsr_rd > lr0, 1);
        stall_rbr = 1'b0;
        for (int i = 0; i < 300 && got_rx.size() < exp_rx.size(); i++) wait_cyc(1);
        check_eq("tmo_byte_kept", got_rx.size() > 0 ? got_rx[got_rx.size()-1] : 8'hxx,
                 exp_rx[exp_rx.size()-1]);
        check_eq("tmo_sticky", bus_err_o, 1);

        check_eq("gap_spacing", gap_err, 0);
        check_eq("cycle_stable", stab_err, 0);
        check_eq("odd_access", odd_cnt, 0);
        check_eq("init_once", init_wr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
